// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with two write ports, NR combinational
// read ports and a per-register pending scoreboard.
// Register 0 is hardwired to zero and is never marked pending.
// Reads are write-first: a same-cycle write to the read address is forwarded,
// with write port 1 taking priority over write port 0.
module regfile_sb #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rd,
  output logic [NR-1:0]    rd_busy,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    wa0,
  input  logic [AW-1:0]    wa1,
  input  logic [DW-1:0]    wd0,
  input  logic [DW-1:0]    wd1,
  input  logic             iss_v,
  input  logic [AW-1:0]    iss_a,
  input  logic             flush,
  output logic [AW:0]      busy_cnt
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_next;
  logic [AW:0]      cnt_next;

  // Writes and issues aimed at register 0 are dropped here so that nothing
  // downstream needs to special-case address zero again.
  logic w0_act;
  logic w1_act;
  logic iss_act;

  assign w0_act  = we0   && (wa0   != '0);
  assign w1_act  = we1   && (wa1   != '0);
  assign iss_act = iss_v && (iss_a != '0);

  // Data storage: port 1 is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (w0_act) begin
        mem[wa0] <= wd0;
      end
      if (w1_act) begin
        mem[wa1] <= wd1;
      end
    end
  end

  // Next pending vector: writes retire, a same-cycle issue re-arms, flush wipes all.
  always_comb begin
    pend_next = pend;
    if (w0_act) begin
      pend_next[wa0] = 1'b0;
    end
    if (w1_act) begin
      pend_next[wa1] = 1'b0;
    end
    if (iss_act) begin
      pend_next[iss_a] = 1'b1;
    end
    if (flush) begin
      pend_next = '0;
    end
    pend_next[0] = 1'b0;
  end

  // Population count of the next pending vector, so the registered count
  // tracks the bits on the same edge.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_next = cnt_next + {{AW{1'b0}}, pend_next[i]};
    end
  end

  // Scoreboard state and its registered count.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend     <= '0;
      busy_cnt <= '0;
    end else begin
      pend     <= pend_next;
      busy_cnt <= cnt_next;
    end
  end

  // One combinational read path per read port.
  for (genvar k = 0; k < NR; k++) begin : g_read
    logic [AW-1:0] addr;
    logic          hit0;
    logic          hit1;
    logic          iss_hit;
    logic [DW-1:0] data;
    logic          busy;

    assign addr    = ra[k*AW +: AW];
    assign hit0    = w0_act && (wa0 == addr);
    assign hit1    = w1_act && (wa1 == addr);
    assign iss_hit = iss_act && (iss_a == addr);

    // Write-first data selection with port 1 over port 0; register 0 reads zero.
    always_comb begin
      data = mem[addr];
      if (hit0) begin
        data = wd0;
      end
      if (hit1) begin
        data = wd1;
      end
      if (addr == '0) begin
        data = '0;
      end
    end

    // A write landing this cycle hides the pending bit unless an issue re-arms it.
    always_comb begin
      busy = pend[addr];
      if ((hit0 || hit1) && !iss_hit) begin
        busy = 1'b0;
      end
    end

    assign rd[k*DW +: DW] = data;
    assign rd_busy[k]     = busy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb with directed and random stimulus.
module tb_regfile_sb;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int DEPTH = 1 << AW;

   logic             clk;
   logic             reset;
   logic [NR*AW-1:0] ra;
   logic [NR*DW-1:0] rd;
   logic [NR-1:0]    rd_busy;
   logic             we0, we1;
   logic [AW-1:0]    wa0, wa1;
   logic [DW-1:0]    wd0, wd1;
   logic             iss_v;
   logic [AW-1:0]    iss_a;
   logic             flush;
   logic [AW:0]      busy_cnt;

   regfile_sb #(.DW(DW), .AW(AW), .NR(NR)) dut (
      .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rd_busy(rd_busy),
      .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
      .iss_v(iss_v), .iss_a(iss_a), .flush(flush), .busy_cnt(busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]      step;
      logic [NR*DW-1:0] rd;
      logic [NR-1:0]    busy;
      logic [AW:0]      cnt;
   } exp_t;

   exp_t expQ [$];
   exp_t monE;

   // Architectural state as the register file should hold it after each edge.
   logic [DW-1:0] memM  [DEPTH];
   bit            pendM [DEPTH];

   int checks   = 0;
   int failures = 0;
   int stepNo   = 0;

   // Compares one cycle's DUT outputs against the expectation popped from the queue.
   task automatic checkOutput(input exp_t e);
      for (int k = 0; k < NR; k++) begin
         checks++;
         if (rd[k*DW +: DW] !== e.rd[k*DW +: DW]) begin
            failures++;
            $display("[TB] FAIL rd%0d step %0d: got %h expected %h", k, e.step, rd[k*DW +: DW], e.rd[k*DW +: DW]);
         end
      end
      checks++;
      if (rd_busy !== e.busy) begin
         failures++;
         $display("[TB] FAIL rd_busy step %0d: got %b expected %b", e.step, rd_busy, e.busy);
      end
      checks++;
      if (busy_cnt !== e.cnt) begin
         failures++;
         $display("[TB] FAIL busy_cnt step %0d: got %0d expected %0d", e.step, busy_cnt, e.cnt);
      end
   endtask

   // Monitor: the DUT presents outputs every cycle; check them mid-cycle.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monE = expQ.pop_front();
         checkOutput(monE);
      end
   end

   // Drives one cycle of inputs, queues the expected outputs for that cycle
   // and then advances the reference model across the coming edge.
   task automatic applyStimulus(
      input logic r, input logic fl, input logic iv, input logic [AW-1:0] ia,
      input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
      input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
      input logic [AW-1:0] r0, input logic [AW-1:0] r1, input bit doCheck);
      exp_t          e;
      logic [AW-1:0] a;
      bit            wrHit;
      int            cnt;
      @(posedge clk);
      #1;
      reset = r; flush = fl; iss_v = iv; iss_a = ia;
      we0 = e0; wa0 = a0; wd0 = d0;
      we1 = e1; wa1 = a1; wd1 = d1;
      ra = {r1, r0};
      if (doCheck) begin
         e = '0;
         e.step = stepNo;
         for (int k = 0; k < NR; k++) begin
            a = (k == 0) ? r0 : r1;
            wrHit = (a != 0) && ((e1 && a1 == a) || (e0 && a0 == a));
            if (a == 0)                e.rd[k*DW +: DW] = '0;
            else if (e1 && a1 == a)    e.rd[k*DW +: DW] = d1;
            else if (e0 && a0 == a)    e.rd[k*DW +: DW] = d0;
            else                       e.rd[k*DW +: DW] = memM[a];
            e.busy[k] = pendM[a] && !(wrHit && !(iv && ia == a));
         end
         cnt = 0;
         for (int i = 0; i < DEPTH; i++) cnt += int'(pendM[i]);
         e.cnt = cnt[AW:0];
         expQ.push_back(e);
      end
      if (r) begin
         for (int i = 0; i < DEPTH; i++) begin
            memM[i]  = '0;
            pendM[i] = 1'b0;
         end
      end else begin
         if (e0 && a0 != 0) memM[a0] = d0;
         if (e1 && a1 != 0) memM[a1] = d1;
         if (fl) begin
            for (int i = 0; i < DEPTH; i++) pendM[i] = 1'b0;
         end else begin
            if (e0 && a0 != 0) pendM[a0] = 1'b0;
            if (e1 && a1 != 0) pendM[a1] = 1'b0;
            if (iv && ia != 0) pendM[ia] = 1'b1;
         end
      end
      stepNo++;
   endtask

   // Shorthands for the directed part of the sequence.
   task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1, 1);
   endtask

   task automatic issue(input logic [AW-1:0] ia, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
      applyStimulus(0, 0, 1, ia, 0, 0, 0, 0, 0, 0, r0, r1, 1);
   endtask

   logic          rr, rf, riv, re0, re1;
   logic [AW-1:0] ria, ra0, ra1, rr0, rr1;
   logic [DW-1:0] rd0, rd1;

   function automatic logic [AW-1:0] randAddr();
      if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, DEPTH - 1));
   endfunction

   initial begin
      int waitCycles;
      for (int i = 0; i < DEPTH; i++) begin
         memM[i]  = '0;
         pendM[i] = 1'b0;
      end
      reset = 1'b1; flush = 1'b0; iss_v = 1'b0; iss_a = '0;
      we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra = '0;

      // Reset, and a write during reset is forwarded but never stored.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 1, 2, 1, 3, 32'hAAAA_5555, 0, 0, 0, 3, 2, 1);
      idle(3, 2);

      // Bypass then stored read.
      applyStimulus(0, 0, 0, 0, 1, 3, 32'hDEAD_BEEF, 0, 0, 0, 3, 1, 1);
      idle(3, 1);

      // Same-address dual write: port 1 wins.
      applyStimulus(0, 0, 0, 0, 1, 7, 32'h11, 1, 7, 32'h22, 7, 7, 1);
      idle(7, 3);

      // Register 0 ignores writes and issues.
      applyStimulus(0, 0, 0, 0, 1, 0, 32'hFFFF, 1, 0, 32'hFFFF, 0, 0, 1);
      issue(0, 0, 7);
      idle(0, 0);

      // Scoreboard set/clear.
      issue(4, 4, 9);
      issue(9, 4, 9);
      idle(4, 9);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h44, 4, 9, 1);
      idle(4, 9);

      // Issue and write to the same register in one cycle.
      applyStimulus(0, 0, 1, 5, 1, 5, 32'h55, 0, 0, 0, 5, 9, 1);
      idle(5, 9);

      // Re-issue of a pending register leaves the count alone.
      issue(5, 5, 9);
      idle(5, 9);

      // Flush beats a same-cycle issue; writes still land.
      issue(10, 10, 6);
      issue(11, 11, 6);
      issue(12, 12, 6);
      applyStimulus(0, 1, 1, 6, 1, 12, 32'hC0DE, 0, 0, 0, 6, 12, 1);
      idle(6, 12);

      // Reset mid-sequence discards data and pending marks.
      issue(13, 13, 12);
      applyStimulus(0, 0, 1, 14, 1, 15, 32'h1515, 1, 16, 32'h1616, 15, 16, 1);
      applyStimulus(1, 0, 1, 17, 1, 18, 32'h1818, 0, 0, 0, 14, 13, 1);
      idle(15, 16);
      idle(14, 13);

      // Random traffic with narrow address ranges to force collisions.
      for (int n = 0; n < 600; n++) begin
         rr  = ($urandom_range(0, 63) == 0);
         rf  = ($urandom_range(0, 15) == 0);
         riv = $urandom_range(0, 1) == 1;
         re0 = $urandom_range(0, 1) == 1;
         re1 = $urandom_range(0, 1) == 1;
         ria = randAddr(); ra0 = randAddr(); ra1 = randAddr();
         rd0 = DW'($urandom); rd1 = DW'($urandom);
         case ($urandom_range(0, 3))
            0:       rr0 = ra0;
            1:       rr0 = ria;
            default: rr0 = randAddr();
         endcase
         case ($urandom_range(0, 3))
            0:       rr1 = ra1;
            1:       rr1 = ria;
            default: rr1 = randAddr();
         endcase
         applyStimulus(rr, rf, riv, ria, re0, ra0, rd0, re1, ra1, rd1, rr0, rr1, 1);
      end

      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 20) begin
         @(posedge clk);
         waitCycles++;
      end
      if (expQ.size() > 0) begin
         failures++;
         $display("[TB] FAIL drain: got %0d queued expectations, expected 0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
